half_duplex_ctrl: RTL

//  Sequential direction controller for a shared half-duplex data bus built from bufif1/bufif0 pairs.

---
 rtl/half_duplex_ctrl_if.sv | 32 +++
 rtl/half_duplex_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/half_duplex_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// half_duplex_ctrl_if : local TX handshake, peer RX path and bus buffer control
// Rev 1.0
// ---------------------------------------------------------------------------
interface half_duplex_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ready;
  logic [WIDTH-1:0] bus_out;
  logic             tx_strobe;
  logic             dir;
  logic [WIDTH-1:0] bus_in;
  logic             peer_strobe;
  logic             peer_req;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             bus_err;

  modport master (
    output tx_valid, tx_data, bus_in, peer_strobe, peer_req,
    input  tx_ready, bus_out, tx_strobe, dir, rx_valid, rx_data, bus_err
  );

  modport slave (
    input  tx_valid, tx_data, bus_in, peer_strobe, peer_req,
    output tx_ready, bus_out, tx_strobe, dir, rx_valid, rx_data, bus_err
  );
endinterface
`default_nettype wire

// File: rtl/half_duplex_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// half_duplex_ctrl : half-duplex bus direction controller with turnaround gaps
// Rev 1.0
// ---------------------------------------------------------------------------
module half_duplex_ctrl #(
  parameter int WIDTH     = 8,
  parameter int TURN      = 2,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  half_duplex_ctrl_if.slave  hd
);
  localparam int TW = $clog2(TURN) + 1;
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [BW-1:0] BURST_ONE = BW'(1);

  typedef enum logic [1:0] {
    S_RX      = 2'd0,
    S_TURN_TX = 2'd1,
    S_TX      = 2'd2,
    S_TURN_RX = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    turn_q;
  logic [BW-1:0]    burst_q;
  logic             dir_q;
  logic             tx_strobe_q;
  logic             rx_valid_q;
  logic             bus_err_q;
  logic [WIDTH-1:0] bus_out_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             tx_ready;
  logic             fire;
  logic             turn_done;
  logic             in_rx;
  logic             in_turn;

  assign in_rx     = (state_q == S_RX);
  assign in_turn   = (state_q == S_TURN_TX) || (state_q == S_TURN_RX);
  assign turn_done = (turn_q == TURN_LAST);
  // Peer may only take over once a full burst has gone out.
  assign tx_ready  = (state_q == S_TX) && !((burst_q == BURST_MAX) && hd.peer_req);
  assign fire      = tx_ready && hd.tx_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RX:      if (hd.tx_valid && !hd.peer_req && !hd.peer_strobe) state_d = S_TURN_TX;
      S_TURN_TX: if (turn_done) state_d = S_TX;
      S_TX:      if (!fire) state_d = S_TURN_RX;
      S_TURN_RX: if (turn_done) state_d = S_RX;
      default:   state_d = S_RX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RX;
      turn_q      <= '0;
      burst_q     <= '0;
      dir_q       <= 1'b0;
      tx_strobe_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_out_q   <= '0;
      rx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= (state_d == S_TX);
      tx_strobe_q <= fire;
      rx_valid_q  <= in_rx && hd.peer_strobe;
      if (fire) bus_out_q <= hd.tx_data;
      if (in_rx && hd.peer_strobe) rx_data_q <= hd.bus_in;
      if (!in_rx && hd.peer_strobe) bus_err_q <= 1'b1;

      if (in_turn && !turn_done) turn_q <= turn_q + TW'(1);
      else turn_q <= '0;

      if (fire) burst_q <= (burst_q == BURST_MAX) ? BURST_ONE : burst_q + BURST_ONE;
      else if (state_q != S_TX) burst_q <= '0;
    end
  end

  assign hd.tx_ready  = tx_ready;
  assign hd.bus_out   = bus_out_q;
  assign hd.tx_strobe = tx_strobe_q;
  assign hd.dir       = dir_q;
  assign hd.rx_valid  = rx_valid_q;
  assign hd.rx_data   = rx_data_q;
  assign hd.bus_err   = bus_err_q;
endmodule
`default_nettype wire
